// File: rtl/rob_pkg.sv
// Shared reorder-buffer types and sizing, also used by the reservation
// stations and the map table.
package rob_pkg;

   localparam int XLEN      = 32;
   localparam int ROB_SIZE  = 8;
   localparam int ROB_TAG_W = $clog2(ROB_SIZE);
   localparam int ROB_CNT_W = ROB_TAG_W + 1;

   typedef logic [ROB_TAG_W-1:0] rob_tag_t;
   typedef logic [ROB_CNT_W-1:0] rob_cnt_t;

   typedef struct packed {
      logic            valid;
      logic            ready;
      logic            has_dest;
      logic            is_branch;
      logic            mispredict;
      logic [4:0]      dest;
      logic [XLEN-1:0] value;
   } rob_entry_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement buffer. Entries are allocated at the tail on
// dispatch, filled from the CDB, and retired one per cycle from the head
// straight into the architectural register file write port.
module reorder_buffer
   import rob_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            dispatch_en,
   input  logic [4:0]      dispatch_dest_reg,
   input  logic            dispatch_has_dest,
   input  logic            dispatch_is_branch,
   output rob_tag_t        dispatch_tag,
   output logic            rob_full,
   output logic            rob_empty,
   input  logic            cdb_valid,
   input  rob_tag_t        cdb_tag,
   input  logic [XLEN-1:0] cdb_value,
   input  logic            cdb_mispredict,
   input  rob_tag_t        rd_tag1,
   input  rob_tag_t        rd_tag2,
   output logic            rd_ready1,
   output logic            rd_ready2,
   output logic [XLEN-1:0] rd_value1,
   output logic [XLEN-1:0] rd_value2,
   output logic [4:0]      reg_addr,
   output logic [XLEN-1:0] wr_data,
   output logic            wr_en,
   output logic            commit_valid,
   output logic            flush
);

   localparam rob_cnt_t FULL_COUNT = rob_cnt_t'(ROB_SIZE);

   rob_entry_t entries   [ROB_SIZE];
   rob_entry_t entries_n [ROB_SIZE];
   rob_tag_t   head, head_n;
   rob_tag_t   tail, tail_n;
   rob_cnt_t   count, count_n;
   logic       dispatch_accept;
   rob_entry_t head_entry;

   assign head_entry   = entries[head];
   assign dispatch_tag = tail;
   assign rob_full     = (count == FULL_COUNT);
   assign rob_empty    = (count == '0);

   // Commit port: everything is derived from registered state only.
   assign commit_valid = head_entry.valid & head_entry.ready;
   assign flush        = commit_valid & head_entry.mispredict;
   assign wr_en        = commit_valid & head_entry.has_dest & (head_entry.dest != 5'd0);
   assign reg_addr     = head_entry.dest;
   assign wr_data      = head_entry.value;

   // Full is judged on the registered count, so a full buffer drops a
   // dispatch even when the head retires in the same cycle.
   assign dispatch_accept = dispatch_en & ~rob_full & ~flush;

   // Operand lookup for dispatching instructions; no CDB bypass here.
   assign rd_ready1 = entries[rd_tag1].valid & entries[rd_tag1].ready;
   assign rd_ready2 = entries[rd_tag2].valid & entries[rd_tag2].ready;
   assign rd_value1 = rd_ready1 ? entries[rd_tag1].value : '0;
   assign rd_value2 = rd_ready2 ? entries[rd_tag2].value : '0;

   // Next-state: flush wins over everything, otherwise apply CDB, commit, dispatch.
   always_comb begin
      // NOTE: every signal gets a default first so no path leaves a latch.
      entries_n = entries;
      head_n    = head;
      tail_n    = tail;
      count_n   = count;

      if (flush) begin
         for (int i = 0; i < ROB_SIZE; i++) begin
            entries_n[i].valid = 1'b0;
            entries_n[i].ready = 1'b0;
         end
         head_n  = '0;
         tail_n  = '0;
         count_n = '0;
      end else begin
         if (cdb_valid && entries[cdb_tag].valid) begin
            entries_n[cdb_tag].value      = cdb_value;
            entries_n[cdb_tag].ready      = 1'b1;
            entries_n[cdb_tag].mispredict = cdb_mispredict & entries[cdb_tag].is_branch;
         end
         if (commit_valid) begin
            entries_n[head].valid = 1'b0;
            head_n                = head + rob_tag_t'(1);
         end
         if (dispatch_accept) begin
            entries_n[tail].valid      = 1'b1;
            entries_n[tail].ready      = 1'b0;
            entries_n[tail].has_dest   = dispatch_has_dest;
            entries_n[tail].is_branch  = dispatch_is_branch;
            entries_n[tail].mispredict = 1'b0;
            entries_n[tail].dest       = dispatch_dest_reg;
            tail_n                     = tail + rob_tag_t'(1);
         end
         count_n = count + rob_cnt_t'(dispatch_accept) - rob_cnt_t'(commit_valid);
      end
   end

   // State register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!reset) begin
         // NOTE: only the valid/ready bits are reset; payload fields are
         // don't-care while invalid, so they need no reset.
         for (int i = 0; i < ROB_SIZE; i++) begin
            entries[i].valid <= 1'b0;
            entries[i].ready <= 1'b0;
         end
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         entries <= entries_n;
         head    <= head_n;
         tail    <= tail_n;
         count   <= count_n;
      end
   end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a queue-based program-order model
// predicts every output each cycle; directed scenarios add literal checks.
module tb_reorder_buffer;
   import rob_pkg::*;

   logic            clk;
   logic            reset;
   logic            dispatch_en;
   logic [4:0]      dispatch_dest_reg;
   logic            dispatch_has_dest;
   logic            dispatch_is_branch;
   rob_tag_t        dispatch_tag;
   logic            rob_full;
   logic            rob_empty;
   logic            cdb_valid;
   rob_tag_t        cdb_tag;
   logic [XLEN-1:0] cdb_value;
   logic            cdb_mispredict;
   rob_tag_t        rd_tag1;
   rob_tag_t        rd_tag2;
   logic            rd_ready1;
   logic            rd_ready2;
   logic [XLEN-1:0] rd_value1;
   logic [XLEN-1:0] rd_value2;
   logic [4:0]      reg_addr;
   logic [XLEN-1:0] wr_data;
   logic            wr_en;
   logic            commit_valid;
   logic            flush;

   reorder_buffer dut (
      .clk                (clk),
      .reset              (reset),
      .dispatch_en        (dispatch_en),
      .dispatch_dest_reg  (dispatch_dest_reg),
      .dispatch_has_dest  (dispatch_has_dest),
      .dispatch_is_branch (dispatch_is_branch),
      .dispatch_tag       (dispatch_tag),
      .rob_full           (rob_full),
      .rob_empty          (rob_empty),
      .cdb_valid          (cdb_valid),
      .cdb_tag            (cdb_tag),
      .cdb_value          (cdb_value),
      .cdb_mispredict     (cdb_mispredict),
      .rd_tag1            (rd_tag1),
      .rd_tag2            (rd_tag2),
      .rd_ready1          (rd_ready1),
      .rd_ready2          (rd_ready2),
      .rd_value1          (rd_value1),
      .rd_value2          (rd_value2),
      .reg_addr           (reg_addr),
      .wr_data            (wr_data),
      .wr_en              (wr_en),
      .commit_valid       (commit_valid),
      .flush              (flush)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Program-order model: the queue holds live instructions oldest first.
   typedef struct {
      int unsigned     tag;
      logic [4:0]      dest;
      bit              has_dest;
      bit              is_branch;
      bit              ready;
      bit              misp;
      logic [XLEN-1:0] value;
   } m_ent_t;

   m_ent_t      m_q[$];
   int unsigned m_tail  = 0;
   bit          m_valid = 0;

   function automatic bit m_find(input int unsigned tag, output int idx);
      idx = -1;
      for (int i = 0; i < m_q.size(); i++)
         if (m_q[i].tag == tag) idx = i;
      return idx >= 0;
   endfunction

   task automatic m_lookup(input int unsigned tag, output bit rdy, output logic [XLEN-1:0] val);
      int idx;
      rdy = 0;
      val = '0;
      if (m_find(tag, idx) && m_q[idx].ready) begin
         rdy = 1;
         val = m_q[idx].value;
      end
   endtask

   task automatic compare_model();
      bit              c, rdy;
      logic [XLEN-1:0] val;
      if (!m_valid) return;
      c = (m_q.size() > 0) && m_q[0].ready;
      check("rob_empty", rob_empty, m_q.size() == 0);
      check("rob_full", rob_full, m_q.size() == ROB_SIZE);
      check("dispatch_tag", dispatch_tag, m_tail);
      check("commit_valid", commit_valid, c);
      check("flush", flush, c && m_q[0].misp);
      check("wr_en", wr_en, c && m_q[0].has_dest && m_q[0].dest != 0);
      if (c) begin
         check("reg_addr", reg_addr, m_q[0].dest);
         check("wr_data", wr_data, m_q[0].value);
      end
      m_lookup(rd_tag1, rdy, val);
      check("rd_ready1", rd_ready1, rdy);
      check("rd_value1", rd_value1, val);
      m_lookup(rd_tag2, rdy, val);
      check("rd_ready2", rd_ready2, rdy);
      check("rd_value2", rd_value2, val);
   endtask

   task automatic model_edge();
      bit     c, fl;
      int     idx;
      int     size_before;
      m_ent_t e;
      if (!reset) begin
         m_q.delete();
         m_tail  = 0;
         m_valid = 1;
         return;
      end
      if (!m_valid) return;
      size_before = m_q.size();
      c  = (size_before > 0) && m_q[0].ready;
      fl = c && m_q[0].misp;
      if (fl) begin
         m_q.delete();
         m_tail = 0;
         return;
      end
      if (cdb_valid && m_find(cdb_tag, idx)) begin
         m_q[idx].ready = 1;
         m_q[idx].value = cdb_value;
         m_q[idx].misp  = cdb_mispredict && m_q[idx].is_branch;
      end
      if (c) void'(m_q.pop_front());
      if (dispatch_en && size_before < ROB_SIZE) begin
         e.tag       = m_tail;
         e.dest      = dispatch_dest_reg;
         e.has_dest  = dispatch_has_dest;
         e.is_branch = dispatch_is_branch;
         e.ready     = 0;
         e.misp      = 0;
         e.value     = '0;
         m_q.push_back(e);
         m_tail = (m_tail + 1) % ROB_SIZE;
      end
   endtask

   // Inputs are already driven (just after a negedge); compare, then clock.
   task automatic step();
      #1;
      compare_model();
      @(posedge clk);
      model_edge();
      @(negedge clk);
   endtask

   task automatic idle();
      reset              = 1'b1;
      dispatch_en        = 1'b0;
      dispatch_dest_reg  = 5'd0;
      dispatch_has_dest  = 1'b0;
      dispatch_is_branch = 1'b0;
      cdb_valid          = 1'b0;
      cdb_tag            = '0;
      cdb_value          = '0;
      cdb_mispredict     = 1'b0;
   endtask

   task automatic disp(input logic [4:0] d, input logic hd, input logic br);
      dispatch_en        = 1'b1;
      dispatch_dest_reg  = d;
      dispatch_has_dest  = hd;
      dispatch_is_branch = br;
   endtask

   task automatic cdb(input int unsigned t, input logic [XLEN-1:0] v, input logic m);
      cdb_valid      = 1'b1;
      cdb_tag        = rob_tag_t'(t);
      cdb_value      = v;
      cdb_mispredict = m;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b0;
      step();
      idle();
   endtask

   initial begin
      idle();
      rd_tag1 = '0;
      rd_tag2 = '0;
      @(negedge clk);

      // Reset held two cycles with dispatch requested: nothing allocates.
      reset = 1'b0;
      disp(5'd3, 1'b1, 1'b0);
      step();
      step();
      idle();
      #1;
      check("reset_empty", rob_empty, 1'b1);
      check("reset_tag", dispatch_tag, 0);
      check("reset_wr_en", wr_en, 1'b0);
      check("reset_rd_ready", rd_ready1, 1'b0);

      // Fill: tags 0..7 then full.
      for (int i = 0; i < ROB_SIZE; i++) begin
         disp(5'(i + 1), 1'b1, 1'b0);
         #1;
         check("fill_tag", dispatch_tag, i);
         step();
      end
      idle();
      #1;
      check("fill_full", rob_full, 1'b1);
      disp(5'd20, 1'b1, 1'b0);
      step();
      idle();
      #1;
      check("full_drop_tag", dispatch_tag, 0);
      cdb(0, 32'h5a, 1'b0);
      step();
      idle();
      disp(5'd21, 1'b1, 1'b0);
      #1;
      check("full_commit_cv", commit_valid, 1'b1);
      step();
      idle();
      #1;
      check("full_commit_notfull", rob_full, 1'b0);
      check("full_commit_drop_tag", dispatch_tag, 0);
      do_reset();

      // Out-of-order completion, in-order commit.
      disp(5'd5, 1'b1, 1'b0); step();
      disp(5'd6, 1'b1, 1'b0); step();
      disp(5'd7, 1'b1, 1'b0); step();
      idle(); cdb(2, 32'h33, 1'b0); step();
      idle(); cdb(0, 32'h11, 1'b0); step();
      idle(); cdb(1, 32'h22, 1'b0);
      #1;
      check("ooo_c0_addr", reg_addr, 5);
      check("ooo_c0_data", wr_data, 32'h11);
      step();
      idle();
      #1;
      check("ooo_c1_addr", reg_addr, 6);
      check("ooo_c1_data", wr_data, 32'h22);
      step();
      #1;
      check("ooo_c2_addr", reg_addr, 7);
      check("ooo_c2_data", wr_data, 32'h33);
      check("ooo_c2_wr_en", wr_en, 1'b1);
      step();
      #1;
      check("ooo_empty", rob_empty, 1'b1);

      // x0 and no-destination commits.
      disp(5'd0, 1'b1, 1'b0); step();
      disp(5'd9, 1'b0, 1'b0); step();
      idle(); cdb(3, 32'haa, 1'b0); step();
      idle(); cdb(4, 32'hbb, 1'b0);
      #1;
      check("x0_cv", commit_valid, 1'b1);
      check("x0_wr_en", wr_en, 1'b0);
      step();
      idle();
      #1;
      check("nodest_cv", commit_valid, 1'b1);
      check("nodest_wr_en", wr_en, 1'b0);
      step();
      do_reset();

      // Mispredict flush with concurrent dispatch and CDB.
      disp(5'd1, 1'b1, 1'b1); step();
      disp(5'd2, 1'b1, 1'b0); step();
      disp(5'd3, 1'b1, 1'b0); step();
      idle(); cdb(0, 32'h77, 1'b1); step();
      idle(); cdb(1, 32'h88, 1'b0); disp(5'd4, 1'b1, 1'b0);
      #1;
      check("mp_flush", flush, 1'b1);
      check("mp_wr_en", wr_en, 1'b1);
      check("mp_addr", reg_addr, 1);
      check("mp_data", wr_data, 32'h77);
      step();
      idle();
      #1;
      check("mp_empty", rob_empty, 1'b1);
      check("mp_tag", dispatch_tag, 0);
      step();
      check("mp_no_commit", commit_valid, 1'b0);

      // Wrap-around: dispatch k, complete k-1, commit k-2 each cycle.
      do_reset();
      for (int k = 0; k < 14; k++) begin
         idle();
         if (k < 12) disp(5'(k + 10), 1'b1, 1'b0);
         if (k >= 1 && k <= 12) cdb((k - 1) % ROB_SIZE, 32'h100 + 32'(k - 1), 1'b0);
         rd_tag1 = rob_tag_t'((k + 6) % ROB_SIZE);
         rd_tag2 = rob_tag_t'((k + 7) % ROB_SIZE);
         if (k == 8) begin
            #1;
            check("wrap_tag", dispatch_tag, 0);
         end
         if (k == 10) begin
            #1;
            check("wrap_rd_ready", rd_ready1, 1'b1);
            check("wrap_rd_value", rd_value1, 32'h108);
         end
         step();
      end
      idle();

      // Randomized traffic against the model.
      for (int n = 0; n < 3000; n++) begin
         idle();
         reset = ($urandom_range(0, 99) != 0);
         if ($urandom_range(0, 99) < 60)
            disp(5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
         if ($urandom_range(0, 99) < 70) begin
            if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
               cdb(m_q[$urandom_range(0, m_q.size() - 1)].tag, $urandom, ($urandom_range(0, 3) == 0));
            else
               cdb($urandom_range(0, ROB_SIZE - 1), $urandom, 1'($urandom_range(0, 1)));
         end
         rd_tag1 = rob_tag_t'($urandom_range(0, ROB_SIZE - 1));
         rd_tag2 = rob_tag_t'($urandom_range(0, ROB_SIZE - 1));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
